// File: rtl/core_pkg.sv
// core_pkg: shared encodings for the RV32I multicycle control sequencer.
// Holds the FSM state type, opcode constants, ALU codes, rd_sel and trap-cause codes.
package core_pkg;

    typedef enum logic [2:0] {
        S_RESET  = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd6,
        S_TRAP   = 3'd7
    } state_t;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    localparam logic [3:0] ALU_ADD    = 4'b0000;
    localparam logic [3:0] ALU_PASS_B = 4'b1010;

    localparam logic [1:0] RD_PC_ADD  = 2'b00;
    localparam logic [1:0] RD_ALU     = 2'b01;
    localparam logic [1:0] RD_MEM     = 2'b10;

    localparam logic [1:0] CAUSE_NONE      = 2'b00;
    localparam logic [1:0] CAUSE_ILLEGAL   = 2'b01;
    localparam logic [1:0] CAUSE_FETCH_TMO = 2'b10;
    localparam logic [1:0] CAUSE_DATA_TMO  = 2'b11;

    localparam logic [2:0] SX_WORD = 3'b010;

    function automatic logic opcode_legal(input logic [6:0] op);
        logic legal;
        case (op)
            OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH,
            OPC_LOAD, OPC_STORE, OPC_OP_IMM, OPC_OP: legal = 1'b1;
            default:                                  legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage

// File: rtl/branch_cond.sv
// branch_cond: resolves the RV32I branch condition from func3 and the ALU compare flags.
// func3 010/011 are reserved encodings and are reported as illegal.
module branch_cond (
    input  logic [2:0] func3,
    input  logic       eq,
    input  logic       a_lt_b,
    input  logic       a_lt_ub,
    output logic       taken,
    output logic       illegal
);

    // Branch outcome and reserved-encoding detection
    always_comb begin
        taken   = 1'b0;
        illegal = 1'b0;
        case (func3)
            3'b000:  taken = eq;
            3'b001:  taken = ~eq;
            3'b100:  taken = a_lt_b;
            3'b101:  taken = ~a_lt_b;
            3'b110:  taken = a_lt_ub;
            3'b111:  taken = ~a_lt_ub;
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/core_sequencer.sv
// core_sequencer: multicycle control FSM for the RV32I core on a single clock, with
// one-cycle latch enables, req/ack memory handshake with bounded wait, traps and halt.
module core_sequencer
    import core_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int TMO_W       = 4,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [6:0]      opcode,
    input  logic [2:0]      func3,
    input  logic            func7b,
    input  logic            eq,
    input  logic            a_lt_b,
    input  logic            a_lt_ub,
    input  logic            mem_ack,
    input  logic            halt_req,
    output logic [3:0]      alu_func,
    output logic            alu_a_sel,
    output logic            alu_b_sel,
    output logic            pc_alu_sel,
    output logic            pc_next_sel,
    output logic [1:0]      rd_sel,
    output logic            addr_sel,
    output logic [2:0]      sx_size,
    output logic            mem_req,
    output logic            mem_we,
    output logic            insn_en,
    output logic            pc_en,
    output logic            rd_en,
    output logic            trap,
    output logic [1:0]      trap_cause,
    output logic            halted,
    output logic [XLEN-1:0] instret
);

    // Last wait-counter value before a missing ack becomes a timeout
    localparam logic [TMO_W-1:0] WAIT_LAST = TMO_W'(MEM_TIMEOUT - 1);

    state_t            state_r;
    logic [TMO_W-1:0]  wait_cnt_r;
    logic [XLEN-1:0]   instret_r;
    logic              trap_r;
    logic [1:0]        trap_cause_r;

    logic is_lui_s, is_auipc_s, is_jal_s, is_jalr_s, is_branch_s;
    logic is_load_s, is_store_s, is_op_s;
    logic br_taken_s, br_illegal_s;
    logic [3:0] alu_func_s;
    logic alu_a_sel_s, alu_b_sel_s, alu_active_s;

    assign is_lui_s    = (opcode == OPC_LUI);
    assign is_auipc_s  = (opcode == OPC_AUIPC);
    assign is_jal_s    = (opcode == OPC_JAL);
    assign is_jalr_s   = (opcode == OPC_JALR);
    assign is_branch_s = (opcode == OPC_BRANCH);
    assign is_load_s   = (opcode == OPC_LOAD);
    assign is_store_s  = (opcode == OPC_STORE);
    assign is_op_s     = (opcode == OPC_OP);

    branch_cond u_branch_cond (
        .func3   (func3),
        .eq      (eq),
        .a_lt_b  (a_lt_b),
        .a_lt_ub (a_lt_ub),
        .taken   (br_taken_s),
        .illegal (br_illegal_s)
    );

    // ALU function and operand selects implied by the current opcode
    always_comb begin
        alu_a_sel_s = is_auipc_s | is_jal_s;
        alu_b_sel_s = ~(is_op_s | is_branch_s);
        case (opcode)
            OPC_OP:     alu_func_s = {func7b, func3};
            OPC_OP_IMM: alu_func_s = {func7b & (func3 == 3'b101), func3};
            OPC_LUI:    alu_func_s = ALU_PASS_B;
            default:    alu_func_s = ALU_ADD;
        endcase
    end

    // ALU controls stay applied from EXEC through WB so alu_out and the flags hold steady
    assign alu_active_s = (state_r == S_EXEC) || (state_r == S_MEM) || (state_r == S_WB);

    // Sequencer state, memory wait counter, trap record and retired-instruction count
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r      <= S_RESET;
            wait_cnt_r   <= '0;
            instret_r    <= '0;
            trap_r       <= 1'b0;
            trap_cause_r <= CAUSE_NONE;
        end else begin
            case (state_r)
                S_RESET: begin
                    state_r    <= S_FETCH;
                    wait_cnt_r <= '0;
                end
                S_FETCH: begin
                    if (mem_ack) begin
                        state_r <= S_DECODE;
                    end else if (wait_cnt_r == WAIT_LAST) begin
                        state_r      <= S_TRAP;
                        trap_r       <= 1'b1;
                        trap_cause_r <= CAUSE_FETCH_TMO;
                    end else begin
                        wait_cnt_r <= wait_cnt_r + TMO_W'(1);
                    end
                end
                S_DECODE: begin
                    if (!opcode_legal(opcode)) begin
                        state_r      <= S_TRAP;
                        trap_r       <= 1'b1;
                        trap_cause_r <= CAUSE_ILLEGAL;
                    end else begin
                        state_r <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (is_branch_s && br_illegal_s) begin
                        state_r      <= S_TRAP;
                        trap_r       <= 1'b1;
                        trap_cause_r <= CAUSE_ILLEGAL;
                    end else if (is_load_s || is_store_s) begin
                        state_r    <= S_MEM;
                        wait_cnt_r <= '0;
                    end else begin
                        state_r <= S_WB;
                    end
                end
                S_MEM: begin
                    if (mem_ack) begin
                        state_r <= S_WB;
                    end else if (wait_cnt_r == WAIT_LAST) begin
                        state_r      <= S_TRAP;
                        trap_r       <= 1'b1;
                        trap_cause_r <= CAUSE_DATA_TMO;
                    end else begin
                        wait_cnt_r <= wait_cnt_r + TMO_W'(1);
                    end
                end
                S_WB: begin
                    instret_r  <= instret_r + XLEN'(1);
                    wait_cnt_r <= '0;
                    state_r    <= halt_req ? S_HALT : S_FETCH;
                end
                S_HALT: begin
                    wait_cnt_r <= '0;
                    state_r    <= halt_req ? S_HALT : S_FETCH;
                end
                S_TRAP: begin
                    state_r <= S_TRAP;
                end
                default: begin
                    state_r <= S_RESET;
                end
            endcase
        end
    end

    // Datapath controls decoded from the registered state and instruction fields
    always_comb begin
        alu_func    = alu_active_s ? alu_func_s  : ALU_ADD;
        alu_a_sel   = alu_active_s ? alu_a_sel_s : 1'b0;
        alu_b_sel   = alu_active_s ? alu_b_sel_s : 1'b0;
        sx_size     = (alu_active_s && (is_load_s || is_store_s)) ? func3 : SX_WORD;
        pc_alu_sel  = 1'b0;
        pc_next_sel = 1'b0;
        rd_sel      = RD_PC_ADD;
        addr_sel    = 1'b0;
        mem_req     = 1'b0;
        mem_we      = 1'b0;
        insn_en     = 1'b0;
        pc_en       = 1'b0;
        rd_en       = 1'b0;
        halted      = 1'b0;
        case (state_r)
            S_FETCH: begin
                mem_req = 1'b1;
                insn_en = mem_ack;
            end
            S_MEM: begin
                mem_req  = 1'b1;
                addr_sel = 1'b1;
                mem_we   = is_store_s;
            end
            S_WB: begin
                pc_en       = 1'b1;
                rd_en       = ~(is_branch_s | is_store_s);
                rd_sel      = (is_jal_s | is_jalr_s) ? RD_PC_ADD :
                              (is_load_s ? RD_MEM : RD_ALU);
                pc_next_sel = is_jalr_s;
                pc_alu_sel  = ~(is_jal_s | is_auipc_s | (is_branch_s & br_taken_s));
            end
            S_HALT: begin
                halted = 1'b1;
            end
            default: begin
                halted = 1'b0;
            end
        endcase
    end

    assign trap       = trap_r;
    assign trap_cause = trap_cause_r;
    assign instret    = instret_r;

endmodule
